sap1_control_sequencer: RTL and testbench

- Generates the 12-bit SAP-1 control word consumed by the control-signal bus splitter.
- Built from a 6-state ring counter (T1..T6) plus an instruction decoder driven by the IR opcode nibble.
- Fixed fetch sequence in T1-T3, execute sequence for LDA/ADD/SUB/OUT in T4-T6, and halt on HLT.
- Sits between the instruction register and the control bus; all datapath load/enable strobes originate here.

---
 rtl/sap1_pkg.sv | 80 ++++++++
 rtl/sap1_control_sequencer_if.sv | 13 +
 rtl/sap1_ring_counter.sv | 32 +++
 rtl/sap1_control_sequencer.sv | 58 +++++
 tb/tb_sap1_control_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants: opcodes, control-word bit map, per-T-state control words.
// Used by the control sequencer, the control-signal bus splitter and the bench.
package sap1_pkg;

    localparam int CW_W    = 12;
    localparam int OPC_W   = 4;
    localparam int NSTATES = 6;

    typedef logic [CW_W-1:0]    cw_t;
    typedef logic [NSTATES-1:0] tstate_t;

    typedef enum logic [OPC_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int CP_BIT     = 11;
    localparam int EP_BIT     = 10;
    localparam int LM_BAR_BIT = 9;
    localparam int CE_BAR_BIT = 8;
    localparam int LI_BAR_BIT = 7;
    localparam int EI_BAR_BIT = 6;
    localparam int LA_BAR_BIT = 5;
    localparam int EA_BIT     = 4;
    localparam int SU_BIT     = 3;
    localparam int EU_BIT     = 2;
    localparam int LB_BAR_BIT = 1;
    localparam int LO_BAR_BIT = 0;

    localparam tstate_t TS_T1 = 6'b000001;
    localparam tstate_t TS_T2 = 6'b000010;
    localparam tstate_t TS_T3 = 6'b000100;
    localparam tstate_t TS_T4 = 6'b001000;
    localparam tstate_t TS_T5 = 6'b010000;
    localparam tstate_t TS_T6 = 6'b100000;

    localparam cw_t CW_IDLE   = 12'h3E3;
    localparam cw_t CW_T1     = 12'h5E3;
    localparam cw_t CW_T2     = 12'hBE3;
    localparam cw_t CW_T3     = 12'h263;
    localparam cw_t CW_LDA_T4 = 12'h1A3;
    localparam cw_t CW_LDA_T5 = 12'h2C3;
    localparam cw_t CW_LDA_T6 = 12'h3E3;
    localparam cw_t CW_ADD_T4 = 12'h1A3;
    localparam cw_t CW_ADD_T5 = 12'h2E1;
    localparam cw_t CW_ADD_T6 = 12'h3C7;
    localparam cw_t CW_SUB_T4 = 12'h1A3;
    localparam cw_t CW_SUB_T5 = 12'h2E1;
    localparam cw_t CW_SUB_T6 = 12'h3CF;
    localparam cw_t CW_OUT_T4 = 12'h3F2;
    localparam cw_t CW_OUT_T5 = 12'h3E3;
    localparam cw_t CW_OUT_T6 = 12'h3E3;

    function automatic logic is_defined_op(logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

    // Execute-phase word; anything outside T4-T6 or an unknown opcode is idle.
    function automatic cw_t exec_cw(logic [OPC_W-1:0] op, tstate_t ts);
        cw_t w;
        w = CW_IDLE;
        case (op)
            OP_LDA: w = (ts == TS_T4) ? CW_LDA_T4 : (ts == TS_T5) ? CW_LDA_T5 :
                        (ts == TS_T6) ? CW_LDA_T6 : CW_IDLE;
            OP_ADD: w = (ts == TS_T4) ? CW_ADD_T4 : (ts == TS_T5) ? CW_ADD_T5 :
                        (ts == TS_T6) ? CW_ADD_T6 : CW_IDLE;
            OP_SUB: w = (ts == TS_T4) ? CW_SUB_T4 : (ts == TS_T5) ? CW_SUB_T5 :
                        (ts == TS_T6) ? CW_SUB_T6 : CW_IDLE;
            OP_OUT: w = (ts == TS_T4) ? CW_OUT_T4 : (ts == TS_T5) ? CW_OUT_T5 :
                        (ts == TS_T6) ? CW_OUT_T6 : CW_IDLE;
            default: w = CW_IDLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Sequencer <-> IR / control-bus signal bundle. master = sequencer side.
interface sap1_control_sequencer_if;
    import sap1_pkg::*;

    logic [OPC_W-1:0] OPCODE;
    cw_t              CONT_SIGNAL;
    tstate_t          TSTATE;
    logic             HLT;

    modport master (input OPCODE, output CONT_SIGNAL, output TSTATE, output HLT);
    modport slave  (output OPCODE, input CONT_SIGNAL, input TSTATE, input HLT);

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter with sync clear, hold, early wrap to T1 and
// recovery from any non-one-hot state.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic    clk,
    input  logic    clr,
    input  logic    hold,
    input  logic    wrap,
    output tstate_t tstate
);

    tstate_t tstate_nxt;
    logic    legal;

    assign legal = $onehot(tstate);

    always_ff @(posedge clk) begin
        if (clr) tstate <= TS_T1;
        else     tstate <= tstate_nxt;
    end

    // Recovery outranks hold so a corrupted state can never freeze the machine.
    always_comb begin
        tstate_nxt = tstate;
        if (!legal)    tstate_nxt = TS_T1;
        else if (hold) tstate_nxt = tstate;
        else if (wrap) tstate_nxt = TS_T1;
        else           tstate_nxt = {tstate[NSTATES-2:0], tstate[NSTATES-1]};
    end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: ring counter + combinational control-word decode.
// Define SEQ_EARLY_END_EN to return to T1 right after the last useful execute state.
module sap1_control_sequencer
    import sap1_pkg::*;
(
    input  logic                     CLK,
    input  logic                     CLR,
    sap1_control_sequencer_if.master bus
);

    tstate_t ts;
    cw_t     cw;
    logic    hlt_q;
    logic    halt_now;
    logic    wrap;

    // HLT executes in T4; the counter must already freeze on that edge.
    assign halt_now = (ts == TS_T4) && (bus.OPCODE == OP_HLT) && !hlt_q;

`ifdef SEQ_EARLY_END_EN
    assign wrap = ((ts == TS_T5) && (bus.OPCODE == OP_LDA)) ||
                  ((ts == TS_T4) && (bus.OPCODE == OP_OUT)) ||
                  ((ts == TS_T3) && !is_defined_op(bus.OPCODE));
`else
    assign wrap = 1'b0;
`endif

    sap1_ring_counter u_ring (
        .clk    (CLK),
        .clr    (CLR),
        .hold   (hlt_q | halt_now),
        .wrap   (wrap),
        .tstate (ts)
    );

    always_ff @(posedge CLK) begin
        if (CLR)           hlt_q <= 1'b0;
        else if (halt_now) hlt_q <= 1'b1;
    end

    always_comb begin
        cw = CW_IDLE;
        if (!hlt_q) begin
            case (ts)
                TS_T1:               cw = CW_T1;
                TS_T2:               cw = CW_T2;
                TS_T3:               cw = CW_T3;
                TS_T4, TS_T5, TS_T6: cw = exec_cw(bus.OPCODE, ts);
                default:             cw = CW_IDLE;
            endcase
        end
    end

    assign bus.CONT_SIGNAL = cw;
    assign bus.TSTATE      = ts;
    assign bus.HLT         = hlt_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Self-checking bench: T-state/halt model plus control-word table checked every
// cycle, with directed literal scenarios and randomized opcode/clear traffic.
module tb_sap1_control_sequencer;

    logic CLK = 1'b0;
    logic CLR = 1'b0;

    sap1_control_sequencer_if bus ();

    sap1_control_sequencer dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model: T-state as a plain number 1..6 plus a halted flag.
    int mt     = 1;
    bit mh     = 1'b0;
    bit mvalid = 1'b0;

    function automatic bit is_def(logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'hE) || (op == 4'hF);
    endfunction

    function automatic logic [11:0] exp_cw(int t, bit h, logic [3:0] op);
        if (h) return 12'h3E3;
        if (t == 1) return 12'h5E3;
        if (t == 2) return 12'hBE3;
        if (t == 3) return 12'h263;
        case (op)
            4'h0: return (t == 4) ? 12'h1A3 : (t == 5) ? 12'h2C3 : 12'h3E3;
            4'h1: return (t == 4) ? 12'h1A3 : (t == 5) ? 12'h2E1 : 12'h3C7;
            4'h2: return (t == 4) ? 12'h1A3 : (t == 5) ? 12'h2E1 : 12'h3CF;
            4'hE: return (t == 4) ? 12'h3F2 : 12'h3E3;
            default: return 12'h3E3;
        endcase
    endfunction

    function automatic bit early_wrap(int t, logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
        return (op == 4'h0 && t == 5) || (op == 4'hE && t == 4) || (!is_def(op) && t == 3);
`else
        return (t < 0) && (op == 4'h0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (CLR) begin
            mt     <= 1;
            mh     <= 1'b0;
            mvalid <= 1'b1;
        end else if (mvalid && !mh) begin
            if (mt == 4 && bus.OPCODE == 4'hF)               mh <= 1'b1;
            else if (mt == 6 || early_wrap(mt, bus.OPCODE)) mt <= 1;
            else                                            mt <= mt + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (mvalid) begin
            chk("m_tstate", {6'b0, bus.TSTATE}, 12'd1 << (mt - 1));
            chk("m_cw", bus.CONT_SIGNAL, exp_cw(mt, mh, bus.OPCODE));
            chk("m_hlt", {11'b0, bus.HLT}, {11'b0, mh});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic setin(input logic c, input logic [3:0] op);
        CLR        = c;
        bus.OPCODE = op;
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [5:0] ts, input logic [11:0] cw);
        chk({nm, "_ts"}, {6'b0, bus.TSTATE}, {6'b0, ts});
        chk({nm, "_cw"}, bus.CONT_SIGNAL, cw);
    endtask

    task automatic reset_with(input logic [3:0] op);
        setin(1'b1, op);
        tick();
    endtask

    logic [3:0] rop;
    logic       rclr;

    initial begin
        CLR        = 1'b0;
        bus.OPCODE = 4'h0;

        // Pin the model table itself.
        chk("model_add_t6", exp_cw(6, 1'b0, 4'h1), 12'h3C7);
        chk("model_out_t4", exp_cw(4, 1'b0, 4'hE), 12'h3F2);
        chk("model_halt", exp_cw(1, 1'b1, 4'h0), 12'h3E3);

        // LDA cycle from reset.
        reset_with(4'h0);
        setin(1'b0, 4'h0); expect_now("lda_t1", 6'h01, 12'h5E3);
        chk("rst_hlt", {11'b0, bus.HLT}, 12'h000);
        tick(); setin(1'b0, 4'h0); expect_now("lda_t2", 6'h02, 12'hBE3);
        tick(); setin(1'b0, 4'h0); expect_now("lda_t3", 6'h04, 12'h263);
        tick(); setin(1'b0, 4'h0); expect_now("lda_t4", 6'h08, 12'h1A3);
        tick(); setin(1'b0, 4'h0); expect_now("lda_t5", 6'h10, 12'h2C3);
        tick(); setin(1'b0, 4'h0);
`ifdef SEQ_EARLY_END_EN
        expect_now("lda_wrap", 6'h01, 12'h5E3);
`else
        expect_now("lda_t6", 6'h20, 12'h3E3);
        tick(); setin(1'b0, 4'h0); expect_now("lda_wrap", 6'h01, 12'h5E3);
`endif

        // SUB, then an immediate switch to ADD in T6.
        reset_with(4'h2);
        repeat (3) begin setin(1'b0, 4'h2); tick(); end
        setin(1'b0, 4'h2); expect_now("sub_t4", 6'h08, 12'h1A3);
        tick(); setin(1'b0, 4'h2); expect_now("sub_t5", 6'h10, 12'h2E1);
        tick(); setin(1'b0, 4'h2); expect_now("sub_t6", 6'h20, 12'h3CF);
        setin(1'b0, 4'h1); expect_now("add_t6", 6'h20, 12'h3C7);
        tick();

        // OUT.
        reset_with(4'hE);
        repeat (3) begin setin(1'b0, 4'hE); tick(); end
        setin(1'b0, 4'hE); expect_now("out_t4", 6'h08, 12'h3F2);
        tick(); setin(1'b0, 4'hE);
`ifdef SEQ_EARLY_END_EN
        expect_now("out_wrap", 6'h01, 12'h5E3);
`else
        expect_now("out_t5", 6'h10, 12'h3E3);
        tick(); setin(1'b0, 4'hE); expect_now("out_t6", 6'h20, 12'h3E3);
`endif

        // Undefined opcode behaves as NOP.
        reset_with(4'h7);
        repeat (3) begin setin(1'b0, 4'h7); tick(); end
        setin(1'b0, 4'h7);
`ifdef SEQ_EARLY_END_EN
        expect_now("nop_wrap", 6'h01, 12'h5E3);
`else
        expect_now("nop_t4", 6'h08, 12'h3E3);
        tick(); setin(1'b0, 4'h7); expect_now("nop_t5", 6'h10, 12'h3E3);
        tick(); setin(1'b0, 4'h7); expect_now("nop_t6", 6'h20, 12'h3E3);
`endif

        // HLT freezes in T4 regardless of later opcodes; CLR releases.
        reset_with(4'hF);
        repeat (3) begin setin(1'b0, 4'hF); tick(); end
        setin(1'b0, 4'hF); expect_now("hlt_t4", 6'h08, 12'h3E3);
        chk("hlt_pre", {11'b0, bus.HLT}, 12'h000);
        tick();
        repeat (20) begin
            setin(1'b0, 4'($urandom_range(0, 15)));
            expect_now("halted", 6'h08, 12'h3E3);
            chk("hlt_set", {11'b0, bus.HLT}, 12'h001);
            tick();
        end
        reset_with(4'h0);
        setin(1'b0, 4'h0); expect_now("hlt_clr", 6'h01, 12'h5E3);
        chk("hlt_clr_flag", {11'b0, bus.HLT}, 12'h000);

        // CLR in T5 of ADD.
        reset_with(4'h1);
        repeat (4) begin setin(1'b0, 4'h1); tick(); end
        setin(1'b0, 4'h1); expect_now("add_t5", 6'h10, 12'h2E1);
        setin(1'b1, 4'h1); tick();
        setin(1'b0, 4'h1); expect_now("midclr", 6'h01, 12'h5E3);

        // Randomized traffic; the negedge compare covers every cycle.
        repeat (600) begin
            case ($urandom_range(0, 9))
                0, 1:    rop = 4'h0;
                2:       rop = 4'h1;
                3:       rop = 4'h2;
                4:       rop = 4'hE;
                5:       rop = 4'hF;
                default: rop = 4'($urandom_range(0, 15));
            endcase
            rclr = mh ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            setin(rclr, rop);
            tick();
        end
        setin(1'b0, 4'h0);
        @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
